// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronises, deserialises and decodes scancodes into held directions and start/continue pulses.
// Optional PS2_WASD_EN macro adds W/S/A/D as a second set of direction keys.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] btns,
  output logic       continue_pulse,
  output logic       start_pulse,
  output logic [7:0] scancode,
  output logic       scan_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} dec_state_e;

  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat_sync_q, dat_sync_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [9:0]       shift_q, shift_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  dec_state_e       state_q, state_d;
  logic [3:0]       arrow_q, arrow_d;
  logic [3:0]       wasd_q, wasd_d;
  logic             space_q, space_d;
  logic             enter_q, enter_d;
  logic [3:0]       btns_q, btns_d;
  logic             cont_q, cont_d;
  logic             start_q, start_d;
  logic [7:0]       scancode_q, scancode_d;
  logic             scan_valid_q, scan_valid_d;
  logic             frame_err_q, frame_err_d;

  logic       fall;
  logic       dat;
  logic       byte_ok;
  logic [7:0] rx_byte;
  logic       evt, evt_make, evt_ext;

  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign dat     = dat_sync_q[1];
  assign rx_byte = shift_q[8:1];

  always_comb begin
    clk_sync_d   = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d   = {dat_sync_q[0], ps2_data};
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    tmo_d        = tmo_q;
    state_d      = state_q;
    arrow_d      = arrow_q;
    wasd_d       = wasd_q;
    space_d      = space_q;
    enter_d      = enter_q;
    scancode_d   = scancode_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    cont_d       = 1'b0;
    start_d      = 1'b0;
    byte_ok      = 1'b0;
    evt          = 1'b0;
    evt_make     = 1'b0;
    evt_ext      = 1'b0;

    // Frame receive: the 11th edge carries the stop bit, checked against the stored start/data/parity.
    if (fall) begin
      tmo_d = '0;
      if (bit_idx_q == 4'd10) begin
        bit_idx_d = 4'd0;
        if (!shift_q[0] && dat && (^shift_q[9:1])) byte_ok = 1'b1;
        else                                         frame_err_d = 1'b1;
      end else begin
        shift_d[bit_idx_q] = dat;
        bit_idx_d          = bit_idx_q + 4'd1;
      end
    end else if (bit_idx_q != 4'd0) begin
      if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        bit_idx_d   = 4'd0;
        tmo_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + CNT_W'(1);
      end
    end else begin
      tmo_d = '0;
    end

    // Prefix tracking: a bad frame drops any half-received E0/F0 sequence.
    if (frame_err_d) begin
      state_d = S_IDLE;
    end else if (byte_ok) begin
      scan_valid_d = 1'b1;
      scancode_d   = rx_byte;
      case (state_q)
        S_IDLE: begin
          if (rx_byte == 8'hE0)      state_d = S_EXT;
          else if (rx_byte == 8'hF0) state_d = S_BRK;
          else begin evt = 1'b1; evt_make = 1'b1; end
        end
        S_EXT: begin
          if (rx_byte == 8'hF0) state_d = S_EXT_BRK;
          else begin evt = 1'b1; evt_make = 1'b1; evt_ext = 1'b1; state_d = S_IDLE; end
        end
        S_BRK: begin
          if (rx_byte == 8'hE0) state_d = S_EXT_BRK;
          else begin evt = 1'b1; state_d = S_IDLE; end
        end
        default: begin
          evt = 1'b1; evt_ext = 1'b1; state_d = S_IDLE;
        end
      endcase
    end

    if (evt) begin
      if (evt_ext) begin
        case (rx_byte)
          8'h75:   arrow_d[3] = evt_make;
          8'h72:   arrow_d[2] = evt_make;
          8'h6B:   arrow_d[1] = evt_make;
          8'h74:   arrow_d[0] = evt_make;
          default: ;
        endcase
      end else begin
        case (rx_byte)
          8'h29: begin cont_d  = evt_make & ~space_q; space_d = evt_make; end
          8'h5A: begin start_d = evt_make & ~enter_q; enter_d = evt_make; end
`ifdef PS2_WASD_EN
          8'h1D:   wasd_d[3] = evt_make;
          8'h1B:   wasd_d[2] = evt_make;
          8'h1C:   wasd_d[1] = evt_make;
          8'h23:   wasd_d[0] = evt_make;
`endif
          default: ;
        endcase
      end
    end

    btns_d = arrow_d | wasd_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync_q   <= '1;
      dat_sync_q   <= '1;
      bit_idx_q    <= '0;
      tmo_q        <= '0;
      state_q      <= S_IDLE;
      arrow_q      <= '0;
      wasd_q       <= '0;
      space_q      <= 1'b0;
      enter_q      <= 1'b0;
      btns_q       <= '0;
      cont_q       <= 1'b0;
      start_q      <= 1'b0;
      scancode_q   <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      bit_idx_q    <= bit_idx_d;
      tmo_q        <= tmo_d;
      state_q      <= state_d;
      arrow_q      <= arrow_d;
      wasd_q       <= wasd_d;
      space_q      <= space_d;
      enter_q      <= enter_d;
      btns_q       <= btns_d;
      cont_q       <= cont_d;
      start_q      <= start_d;
      scancode_q   <= scancode_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign btns           = btns_q;
  assign continue_pulse = cont_q;
  assign start_pulse    = start_q;
  assign scancode       = scancode_q;
  assign scan_valid     = scan_valid_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed test-plan scenarios followed by random scancode traffic against a keyboard model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
  localparam int TMO = 600;
  localparam int H   = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] btns;
  logic       continue_pulse, start_pulse, scan_valid, frame_err;
  logic [7:0] scancode;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .CNT_W(18)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .btns(btns), .continue_pulse(continue_pulse), .start_pulse(start_pulse),
    .scancode(scancode), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  // Event log of one-cycle strobes, sampled away from the active edge.
  int         sv_cnt = 0, err_cnt = 0, cont_cnt = 0, start_cnt = 0;
  logic [3:0] btns_at_sv = 4'h0;
  always @(negedge clk) begin
    if (scan_valid) begin sv_cnt++; btns_at_sv = btns; end
    if (frame_err) err_cnt++;
    if (continue_pulse) cont_cnt++;
    if (start_pulse) start_cnt++;
  end

  // Keyboard model: prefix flags plus sets of held keys.
  logic       m_ext = 0, m_brk = 0, m_space = 0, m_enter = 0;
  logic [3:0] m_arrow = 0, m_wasd = 0, m_btns_sv = 0;
  logic [7:0] exp_code = 0;
  int         exp_sv = 0, exp_err = 0, exp_cont = 0, exp_start = 0;
  int         n_cmp = 0, n_bad = 0;

  function automatic int arrow_idx(input logic [7:0] b);
    case (b)
      8'h75: return 3;
      8'h72: return 2;
      8'h6B: return 1;
      8'h74: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int wasd_idx(input logic [7:0] b);
`ifdef PS2_WASD_EN
    case (b)
      8'h1D: return 3;
      8'h1B: return 2;
      8'h1C: return 1;
      8'h23: return 0;
      default: return -1;
    endcase
`else
    return (b == 8'hFF) ? -2 : -1;
`endif
  endfunction

  task automatic model_err();
    exp_err++;
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_space = 0; m_enter = 0;
    m_arrow = 0; m_wasd = 0; exp_code = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic bad);
    logic make, ext;
    int k;
    if (bad) begin model_err(); return; end
    exp_sv++;
    exp_code = b;
    if (b == 8'hE0 && !m_ext) m_ext = 1;
    else if (b == 8'hF0 && !m_brk) m_brk = 1;
    else begin
      make = !m_brk;
      ext  = m_ext;
      m_ext = 0;
      m_brk = 0;
      if (ext) begin
        k = arrow_idx(b);
        if (k >= 0) m_arrow[k] = make;
      end else if (b == 8'h29) begin
        if (make && !m_space) exp_cont++;
        m_space = make;
      end else if (b == 8'h5A) begin
        if (make && !m_enter) exp_start++;
        m_enter = make;
      end else begin
        k = wasd_idx(b);
        if (k >= 0) m_wasd[k] = make;
      end
    end
    m_btns_sv = m_arrow | m_wasd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      repeat (H) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic bad);
    ps2_bits(frame_of(b, bad), 0, 10);
    repeat (4 * H) @(posedge clk);
    model_byte(b, bad);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".scan_valid_cnt"}, sv_cnt, exp_sv);
    chk({tag, ".frame_err_cnt"}, err_cnt, exp_err);
    chk({tag, ".continue_cnt"}, cont_cnt, exp_cont);
    chk({tag, ".start_cnt"}, start_cnt, exp_start);
    chk({tag, ".scancode"}, scancode, exp_code);
    chk({tag, ".btns"}, btns, m_arrow | m_wasd);
    chk({tag, ".btns_at_sv"}, btns_at_sv, m_btns_sv);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".btns"}, btns, 0);
    chk({tag, ".scancode"}, scancode, 0);
    chk({tag, ".scan_valid"}, scan_valid, 0);
    chk({tag, ".frame_err"}, frame_err, 0);
    chk({tag, ".continue"}, continue_pulse, 0);
    chk({tag, ".start"}, start_pulse, 0);
  endtask

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                            8'h29, 8'h5A, 8'hAA, 8'h1D, 8'h1B, 8'hFA};

  initial begin
    int c0, s0, st0;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    repeat (5) @(posedge clk);

    send(8'hE0, 0); check_all("e0");
    chk("e0.code", scancode, 8'hE0);
    send(8'h75, 0); check_all("up_make");
    chk("up_make.btns_fixed", btns, 4'b1000);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0); check_all("up_break");
    chk("up_break.btns_fixed", btns, 4'b0000);

    c0 = cont_cnt;
    send(8'h29, 0); check_all("space1");
    send(8'h29, 0); check_all("space2");
    send(8'h29, 0); check_all("space3");
    send(8'hF0, 0); send(8'h29, 0); check_all("space_brk");
    send(8'h29, 0); check_all("space4");
    chk("space.pulses_fixed", cont_cnt - c0, 2);

    s0 = sv_cnt; st0 = start_cnt;
    send(8'h5A, 1); check_all("enter_bad");
    chk("enter_bad.no_sv", sv_cnt - s0, 0);
    chk("enter_bad.no_start", start_cnt - st0, 0);
    send(8'h5A, 0); check_all("enter_good");
    chk("enter_good.start_fixed", start_cnt - st0, 1);

    ps2_bits(frame_of(8'hE0, 0), 0, 4);
    repeat (TMO / 2) @(posedge clk);
    chk("tmo.early", err_cnt, exp_err);
    repeat (TMO) @(posedge clk);
    model_err();
    check_all("tmo");
    send(8'hE0, 0); send(8'h74, 0); check_all("right_make");
    chk("right_make.bit0", btns[0], 1'b1);

    send(8'hE0, 0); send(8'h6B, 0); check_all("left_make");
    send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 1); check_all("left_bad_brk");
    chk("left_bad_brk.bit1", btns[1], 1'b1);
    send(8'h6B, 0); check_all("plain_6b");
    chk("plain_6b.btns_fixed", btns, 4'b0011);

    send(8'hE0, 0);
    ps2_bits(frame_of(8'h72, 0), 0, 4);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    check_zero("mid_reset");
    model_reset();
    ps2_bits(frame_of(8'h72, 0), 5, 10);
    repeat (TMO + 100) @(posedge clk);
    model_err();
    check_all("after_reset");
    send(8'hE0, 0); send(8'h72, 0); check_all("down_make");
    chk("down_make.btns_fixed", btns, 4'b0100);

    for (int n = 0; n < 80; n++) begin
      b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
      send(b, $urandom_range(0, 9) == 0);
      check_all("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
